// File: rtl/gpio_in_debounce.sv
// ---------------------------------------------------------------------------
// gpio_in_debounce
//
// Purpose:
//   Conditions raw button/pad levels for the SoC GPIO input register.
//   - Each channel first passes through a two-flop synchronizer.
//   - A small per-channel FSM then accepts a new level only after it has been
//     stable for DEBOUNCE_CYCLES consecutive cycles.
//   - Optional one-cycle rise/fall pulses are produced on accepted changes.
//
// Parameters:
//   WIDTH           - number of independent input channels
//   DEBOUNCE_CYCLES - stable cycles needed to accept a new level (1..65535)
//
// Ports:
//   clk     - single clock; all state updates on its rising edge
//   rst_n   - synchronous active-low reset
//   din     - raw asynchronous pad levels
//   filt_en - 1 = debounce active, 0 = bypass (dout follows synced input)
//   dout    - debounced levels toward the SoC gpio_din
//   rise    - one-cycle pulse per channel on an accepted 0->1 change
//   fall    - one-cycle pulse per channel on an accepted 1->0 change
//
// Build option:
//   GPIO_DEBOUNCE_EDGE_EN - when defined, rise/fall are generated from edge
//                           registers; when undefined, both ports are tied
//                           to 0 and no edge registers exist. dout behaves
//                           identically in both builds.
// ---------------------------------------------------------------------------
module gpio_in_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             filt_en,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Counter just wide enough to hold DEBOUNCE_CYCLES; it never goes past
  // DEBOUNCE_CYCLES-1 because the level is accepted at that value.
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // Channel FSM encoding
  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  // Reject illegal debounce lengths at elaboration time.
  generate
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
      $error("gpio_in_debounce: DEBOUNCE_CYCLES must be in 1..65535");
    end
  endgenerate

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_dout;
  logic [0:0]       r_state [WIDTH];
  logic [CNT_W-1:0] r_cnt   [WIDTH];

  logic [WIDTH-1:0] w_dout_nxt;
  logic [0:0]       w_state_nxt [WIDTH];
  logic [CNT_W-1:0] w_cnt_nxt   [WIDTH];

  // Two-flop synchronizer: r_s2 is the only version of din used downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
    end
  end

  // Next-state logic for every channel. Bypass mode forces each channel to
  // STABLE with a zero count, so re-enabling the filter always starts a fresh
  // debounce from whatever dout currently holds. With DEBOUNCE_CYCLES==1 a
  // mismatch seen in STABLE is accepted straight away, which keeps the
  // overall latency at DEBOUNCE_CYCLES+2 edges for every legal length.
  always_comb begin
    w_dout_nxt = r_dout;
    for (int i = 0; i < WIDTH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
    end

    for (int i = 0; i < WIDTH; i++) begin
      if (!filt_en) begin
        w_state_nxt[i] = ST_STABLE;
        w_cnt_nxt[i]   = CNT_ZERO;
        w_dout_nxt[i]  = r_s2[i];
      end else begin
        case (r_state[i])
          ST_STABLE: begin
            if (r_s2[i] != r_dout[i]) begin
              if (DEBOUNCE_CYCLES == 1) begin
                w_dout_nxt[i] = r_s2[i];
              end else begin
                w_state_nxt[i] = ST_PENDING;
                w_cnt_nxt[i]   = CNT_ONE;
              end
            end
          end
          ST_PENDING: begin
            if (r_s2[i] == r_dout[i]) begin
              // Glitch: input fell back before the window completed.
              w_state_nxt[i] = ST_STABLE;
              w_cnt_nxt[i]   = CNT_ZERO;
            end else if (r_cnt[i] == CNT_LAST) begin
              w_dout_nxt[i]  = r_s2[i];
              w_state_nxt[i] = ST_STABLE;
              w_cnt_nxt[i]   = CNT_ZERO;
            end else begin
              w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
            end
          end
          default: begin
            w_state_nxt[i] = ST_STABLE;
            w_cnt_nxt[i]   = CNT_ZERO;
          end
        endcase
      end
    end
  end

  // Channel state, counters and debounced outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= ST_STABLE;
        r_cnt[i]   <= CNT_ZERO;
      end
    end else begin
      r_dout <= w_dout_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  assign dout = r_dout;

`ifdef GPIO_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // Edge pulses are registered on the same edge that updates dout, so each
  // pulse is high for exactly the cycle following the accepted change.
  // Because dout is 0 out of reset and cannot move on the first edge after
  // release, no spurious pulse appears right after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_dout_nxt & ~r_dout;
      r_fall <= ~w_dout_nxt & r_dout;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule
